// File: rtl/hci_mem_bank_adapter_pkg.sv
// Shared types and helpers for the memory-bank side of the HCI interconnect.
package hci_mem_bank_adapter_pkg;

   typedef enum logic {
      BANK_INIT  = 1'b0,
      BANK_READY = 1'b1
   } hci_bank_state_e;

   // Number of byte-offset address bits for a DW-bit word.
   function automatic int unsigned hci_boff(input int unsigned dw);
      return $clog2(dw / 32'd8);
   endfunction

endpackage

// File: rtl/hci_mem_intf.sv
// One HCI memory channel: request fields towards the bank, response fields back.
interface hci_mem_intf #(
   parameter int unsigned DW     = 32,
   parameter int unsigned IW     = 8,
   parameter int unsigned UW     = 1,
   parameter int unsigned ADDR_W = 32
);
   logic              req;
   logic              gnt;
   logic [ADDR_W-1:0] add;
   logic              we_n;
   logic [DW/8-1:0]   be;
   logic [DW-1:0]     data;
   logic [IW-1:0]     id;
   logic [UW-1:0]     user;
   logic [DW-1:0]     r_data;
   logic [IW-1:0]     r_id;
   logic [UW-1:0]     r_user;

   modport master (
      output req, add, we_n, be, data, id, user,
      input  gnt, r_data, r_id, r_user
   );

   modport slave (
      input  req, add, we_n, be, data, id, user,
      output gnt, r_data, r_id, r_user
   );
endinterface

// File: rtl/hci_mem_resp_pipe.sv
// Read-response alignment pipe: stage 1 tracks valid/id/user against the bank
// latency, optional stage 2 also registers the read data.
module hci_mem_resp_pipe #(
   parameter int unsigned DW        = 32,
   parameter int unsigned IW        = 8,
   parameter int unsigned UW        = 1,
   parameter int unsigned RDATA_REG = 0
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          capture_i,
   input  logic [IW-1:0] id_i,
   input  logic [UW-1:0] user_i,
   input  logic [DW-1:0] rdata_i,
   output logic          r_valid_o,
   output logic [DW-1:0] r_data_o,
   output logic [IW-1:0] r_id_o,
   output logic [UW-1:0] r_user_o
);

   logic          kill_s;
   logic          v1_q, v1_d;
   logic [IW-1:0] id1_q, id1_d;
   logic [UW-1:0] user1_q, user1_d;

   assign kill_s = rst_i | flush_i;

   // Stage 1 next state: id/user only move on a granted read.
   always_comb begin
      v1_d    = capture_i;
      id1_d   = id1_q;
      user1_d = user1_q;
      if (capture_i) begin
         id1_d   = id_i;
         user1_d = user_i;
      end else begin
         id1_d   = id1_q;
         user1_d = user1_q;
      end
   end

   // Stage 1 registers with synchronous reset/flush.
   always_ff @(posedge clk_i) begin
      if (kill_s) begin
         v1_q    <= 1'b0;
         id1_q   <= '0;
         user1_q <= '0;
      end else begin
         v1_q    <= v1_d;
         id1_q   <= id1_d;
         user1_q <= user1_d;
      end
   end

   if (RDATA_REG != 0) begin : g_reg
      logic          v2_q, v2_d;
      logic [DW-1:0] data2_q, data2_d;
      logic [IW-1:0] id2_q, id2_d;
      logic [UW-1:0] user2_q, user2_d;

      // Stage 2 next state: capture bank data alongside the stage-1 tags.
      always_comb begin
         v2_d    = v1_q;
         data2_d = data2_q;
         id2_d   = id2_q;
         user2_d = user2_q;
         if (v1_q) begin
            data2_d = rdata_i;
            id2_d   = id1_q;
            user2_d = user1_q;
         end else begin
            data2_d = data2_q;
         end
      end

      // Stage 2 registers with synchronous reset/flush.
      always_ff @(posedge clk_i) begin
         if (kill_s) begin
            v2_q    <= 1'b0;
            data2_q <= '0;
            id2_q   <= '0;
            user2_q <= '0;
         end else begin
            v2_q    <= v2_d;
            data2_q <= data2_d;
            id2_q   <= id2_d;
            user2_q <= user2_d;
         end
      end

      assign r_valid_o = v2_q & ~kill_s;
      assign r_data_o  = data2_q;
      assign r_id_o    = id2_q;
      assign r_user_o  = user2_q;
   end else begin : g_direct
      // A response flushed in the same cycle it would appear is never shown.
      assign r_valid_o = v1_q & ~kill_s;
      assign r_data_o  = rdata_i;
      assign r_id_o    = id1_q;
      assign r_user_o  = user1_q;
   end

endmodule

// File: rtl/hci_mem_bank_adapter.sv
// Terminates one HCI memory channel onto a single-port bank: grant, bank pins,
// response alignment, and an init walk that fills the bank before traffic.
module hci_mem_bank_adapter
   import hci_mem_bank_adapter_pkg::*;
#(
   parameter int unsigned   AW         = 10,
   parameter int unsigned   DW         = 32,
   parameter int unsigned   IW         = 8,
   parameter int unsigned   UW         = 1,
   parameter int unsigned   RDATA_REG  = 0,
   parameter int unsigned   INIT_EN    = 1,
   parameter logic [DW-1:0] INIT_VALUE = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   hci_mem_intf.slave        tcdm,
   output logic              r_valid_o,
   output logic              init_done_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [AW-1:0]     mem_addr_o,
   output logic [DW-1:0]     mem_wdata_o,
   output logic [DW/8-1:0]   mem_be_o,
   input  logic [DW-1:0]     mem_rdata_i
);

   localparam int unsigned     BOFF        = hci_boff(DW);
   localparam logic [AW-1:0]   CTR_LAST    = '1;
   localparam hci_bank_state_e START_STATE = (INIT_EN != 0) ? BANK_INIT : BANK_READY;
   localparam logic            START_DONE  = (INIT_EN != 0) ? 1'b0 : 1'b1;

   hci_bank_state_e state_q, state_d;
   logic [AW-1:0]   ctr_q, ctr_d;
   logic            done_q, done_d;
   logic            flush_s;
   logic            gnt_s;
   logic            rd_capture_s;
   logic            unused_add;

   assign flush_s    = rst_i | clear_i;
   assign unused_add = ^tcdm.add;

   // FSM next state: clear restarts the walk ahead of any other event.
   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      done_d  = done_q;
      if (clear_i) begin
         state_d = START_STATE;
         ctr_d   = '0;
         done_d  = START_DONE;
      end else begin
         case (state_q)
            BANK_INIT: begin
               ctr_d = ctr_q + AW'(1);
               if (ctr_q == CTR_LAST) begin
                  state_d = BANK_READY;
                  done_d  = 1'b1;
               end else begin
                  state_d = BANK_INIT;
                  done_d  = 1'b0;
               end
            end
            BANK_READY: begin
               state_d = BANK_READY;
               done_d  = 1'b1;
            end
            default: begin
               state_d = START_STATE;
               ctr_d   = '0;
               done_d  = START_DONE;
            end
         endcase
      end
   end

   // FSM state, init counter and registered init_done.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= START_STATE;
         ctr_q   <= '0;
         done_q  <= START_DONE;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         done_q  <= done_d;
      end
   end

   // Bank pin mux: init walk, pass-through when ready, idle during reset/clear.
   always_comb begin
      gnt_s       = 1'b0;
      mem_ce_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (flush_s) begin
         gnt_s = 1'b0;
      end else if (state_q == BANK_INIT) begin
         mem_ce_o    = 1'b1;
         mem_we_o    = 1'b1;
         mem_addr_o  = ctr_q;
         mem_wdata_o = INIT_VALUE;
         mem_be_o    = '1;
      end else begin
         gnt_s       = tcdm.req;
         mem_ce_o    = tcdm.req;
         mem_we_o    = ~tcdm.we_n;
         mem_addr_o  = tcdm.add[AW+BOFF-1:BOFF];
         mem_wdata_o = tcdm.data;
         mem_be_o    = tcdm.be;
      end
   end

   assign tcdm.gnt     = gnt_s;
   assign init_done_o  = done_q;
   assign rd_capture_s = gnt_s & tcdm.we_n;

   hci_mem_resp_pipe #(
      .DW        (DW),
      .IW        (IW),
      .UW        (UW),
      .RDATA_REG (RDATA_REG)
   ) i_resp_pipe (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (clear_i),
      .capture_i (rd_capture_s),
      .id_i      (tcdm.id),
      .user_i    (tcdm.user),
      .rdata_i   (mem_rdata_i),
      .r_valid_o (r_valid_o),
      .r_data_o  (tcdm.r_data),
      .r_id_o    (tcdm.r_id),
      .r_user_o  (tcdm.r_user)
   );

endmodule
